// File: rtl/demux_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux_if
//  Brief    : One AXI4-Stream input and NUM_QUEUES packed AXI4-Stream outputs
//             for the packet demultiplexer.
//  Revision : 1.0  initial release
// ============================================================================
interface demux_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128,
    parameter int NUM_QUEUES  = 8
);
    logic [DATA_WIDTH-1:0]               s_axis_tdata;
    logic [DATA_WIDTH/8-1:0]             s_axis_tkeep;
    logic [TUSER_WIDTH-1:0]              s_axis_tuser;
    logic                                s_axis_tvalid;
    logic                                s_axis_tready;
    logic                                s_axis_tlast;

    logic [NUM_QUEUES*DATA_WIDTH-1:0]    m_axis_tdata;
    logic [NUM_QUEUES*DATA_WIDTH/8-1:0]  m_axis_tkeep;
    logic [NUM_QUEUES*TUSER_WIDTH-1:0]   m_axis_tuser;
    logic [NUM_QUEUES-1:0]               m_axis_tvalid;
    logic [NUM_QUEUES-1:0]               m_axis_tready;
    logic [NUM_QUEUES-1:0]               m_axis_tlast;

    // Upstream source feeding the demux and downstream queues draining it.
    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );

    // The demux itself.
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );
endinterface
`default_nettype wire

// File: rtl/demux.sv
`default_nettype none
// ============================================================================
//  Module   : demux
//  Brief    : 1-to-NUM_QUEUES AXI4-Stream packet demultiplexer with drop
//             support and a single registered output beat.
//  Revision : 1.0  initial release
// ============================================================================
module demux #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES           = 8,
    parameter int SEL_LSB              = 24,
    parameter int DROP_BIT             = 127
) (
    input  wire logic        axis_aclk,
    input  wire logic        axis_resetn,
    demux_if.slave           bus,
    output logic [31:0]      drop_count
);

    localparam int c_selw   = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam int c_dw     = C_M_AXIS_DATA_WIDTH;
    localparam int c_kw     = C_M_AXIS_DATA_WIDTH / 8;
    localparam int c_uw     = C_M_AXIS_TUSER_WIDTH;
    localparam logic [c_selw:0] c_nq_ext = (c_selw + 1)'(NUM_QUEUES);

    typedef enum logic [1:0] {
        ST_HEAD = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_selw-1:0]       r_cur_q;
    logic [c_selw-1:0]       r_out_q;
    logic                    r_out_valid;
    logic [c_dw-1:0]         r_data;
    logic [c_kw-1:0]         r_keep;
    logic [c_uw-1:0]         r_user;
    logic                    r_last;
    logic [31:0]             r_drop_count;

    logic [C_S_AXIS_DATA_WIDTH-1:0]    w_in_data;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]  w_in_keep;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   w_in_user;
    logic [c_selw-1:0]       w_sel;
    logic                    w_head_drop;
    logic                    w_drain;
    logic                    w_s_ready;
    logic                    w_accept;
    logic                    w_load;
    logic [c_selw-1:0]       w_load_q;
    logic                    w_drop_pkt;

    assign w_in_data   = bus.s_axis_tdata;
    assign w_in_keep   = bus.s_axis_tkeep;
    assign w_in_user   = bus.s_axis_tuser;

    assign w_sel       = w_in_user[SEL_LSB +: c_selw];
    assign w_head_drop = w_in_user[DROP_BIT] | ({1'b0, w_sel} >= c_nq_ext);

    // The output register frees up either when empty or when its beat leaves
    // this cycle; in DROP nothing is loaded so input is always consumed.
    assign w_drain     = r_out_valid & bus.m_axis_tready[r_out_q];
    assign w_s_ready   = axis_resetn &
                         ((r_state == ST_DROP) | ~r_out_valid | w_drain);
    assign w_accept    = bus.s_axis_tvalid & w_s_ready;

    assign bus.s_axis_tready = w_s_ready;
    assign drop_count        = r_drop_count;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_q    = r_cur_q;
        w_drop_pkt  = 1'b0;
        case (r_state)
            ST_HEAD: begin
                if (w_accept) begin
                    if (w_head_drop) begin
                        w_drop_pkt  = 1'b1;
                        w_state_nxt = bus.s_axis_tlast ? ST_HEAD : ST_DROP;
                    end else begin
                        w_load      = 1'b1;
                        w_load_q    = w_sel;
                        w_state_nxt = bus.s_axis_tlast ? ST_HEAD : ST_FWD;
                    end
                end
            end
            ST_FWD: begin
                if (w_accept) begin
                    w_load   = 1'b1;
                    w_load_q = r_cur_q;
                    if (bus.s_axis_tlast) begin
                        w_state_nxt = ST_HEAD;
                    end
                end
            end
            ST_DROP: begin
                if (w_accept && bus.s_axis_tlast) begin
                    w_state_nxt = ST_HEAD;
                end
            end
            default: begin
                w_state_nxt = ST_HEAD;
            end
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state      <= ST_HEAD;
            r_cur_q      <= '0;
            r_out_q      <= '0;
            r_out_valid  <= 1'b0;
            r_data       <= '0;
            r_keep       <= '0;
            r_user       <= '0;
            r_last       <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_cur_q     <= w_load_q;
                r_out_q     <= w_load_q;
                r_out_valid <= 1'b1;
                r_data      <= w_in_data;
                r_keep      <= w_in_keep;
                r_user      <= w_in_user;
                r_last      <= bus.s_axis_tlast;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
            if (w_drop_pkt) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

    // Every queue sees the same beat; only the selected one is told it is valid.
    generate
        for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_out
            localparam logic [c_selw-1:0] c_idx = c_selw'(i);
            assign bus.m_axis_tdata[i*c_dw +: c_dw] = r_data;
            assign bus.m_axis_tkeep[i*c_kw +: c_kw] = r_keep;
            assign bus.m_axis_tuser[i*c_uw +: c_uw] = r_user;
            assign bus.m_axis_tlast[i]              = r_last;
            assign bus.m_axis_tvalid[i]             = r_out_valid & (r_out_q == c_idx);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux
//  Brief    : Directed stimulus for demux, checked every cycle against a
//             packet-level reference model plus literal spot checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int UW = 128;
    localparam int NQ = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] drop_count;

    demux_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW), .NUM_QUEUES(NQ)) u_if ();

    demux #(
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (UW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .NUM_QUEUES           (NQ),
        .SEL_LSB              (24),
        .DROP_BIT             (127)
    ) u_dut (
        .axis_aclk   (clk),
        .axis_resetn (rst_n),
        .bus         (u_if.slave),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model: packets in, beats out ----------------
    typedef struct {
        int          q;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    beat_t       mq[$];
    bit          m_in_pkt = 0;
    bit          m_drop   = 0;
    int          m_q      = 0;
    logic [31:0] m_drops  = 0;

    function automatic bit model_ready();
        if (!rst_n) return 1'b0;
        if (m_in_pkt && m_drop) return 1'b1;
        return (mq.size() == 0) || (u_if.m_axis_tready[mq[0].q] == 1'b1);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_in_pkt = 0;
                m_drop   = 0;
                m_drops  = 0;
            end else begin
                bit rdy, drn;
                int sel;
                beat_t b;
                rdy = model_ready();
                drn = (mq.size() > 0) && u_if.m_axis_tready[mq[0].q];
                if (drn) void'(mq.pop_front());
                if (u_if.s_axis_tvalid && rdy) begin
                    b.d = u_if.s_axis_tdata;
                    b.k = u_if.s_axis_tkeep;
                    b.u = u_if.s_axis_tuser;
                    b.l = u_if.s_axis_tlast;
                    if (!m_in_pkt) begin
                        sel    = int'(u_if.s_axis_tuser[26:24]);
                        m_drop = u_if.s_axis_tuser[127] || (sel >= NQ);
                        m_q    = sel;
                        if (m_drop) m_drops = m_drops + 1;
                    end
                    b.q = m_q;
                    if (!m_drop) mq.push_back(b);
                    m_in_pkt = !u_if.s_axis_tlast;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            logic [NQ-1:0] exp_v;
            int q;
            @(negedge clk);
            exp_v = '0;
            if (mq.size() > 0) exp_v[mq[0].q] = 1'b1;
            chk("m_tvalid", u_if.m_axis_tvalid, exp_v);
            chk("s_tready", u_if.s_axis_tready, model_ready());
            chk("drop_count", drop_count, m_drops);
            if (mq.size() > 0) begin
                q = mq[0].q;
                chk("m_tdata", u_if.m_axis_tdata[q*DW +: DW], mq[0].d);
                chk("m_tkeep", u_if.m_axis_tkeep[q*KW +: KW], mq[0].k);
                chk("m_tuser", u_if.m_axis_tuser[q*UW +: UW], mq[0].u);
                chk("m_tlast", u_if.m_axis_tlast[q], mq[0].l);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic [UW-1:0] u, input logic l);
        int  n;
        bit  rdy;
        u_if.s_axis_tdata  = d;
        u_if.s_axis_tkeep  = k;
        u_if.s_axis_tuser  = u;
        u_if.s_axis_tlast  = l;
        u_if.s_axis_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            rdy = u_if.s_axis_tready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout at %0t: s_tready stayed 0 for %0d cycles, required 1", $time, n);
                break;
            end
        end
        #1;
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [15:0] tag, input int j);
        logic [15:0] jj;
        jj = 16'(j);
        return {8{tag, jj}};
    endfunction

    task automatic send_pkt(input int sel, input bit drp, input int nb,
                            input logic [15:0] tag, input int tail_sel, input bit hold);
        logic [UW-1:0] u;
        for (int j = 0; j < nb; j++) begin
            u = '0;
            u[15:0] = tag;
            u[60:45] = 16'(j);
            if (j == 0) begin
                u[26:24] = 3'(sel);
                u[127]   = drp;
            end else begin
                u[26:24] = 3'(tail_sel);
            end
            send_beat(mk_data(tag, j), 32'hFFFF_FFFF >> j, u, (j == nb - 1));
        end
        if (!hold) u_if.s_axis_tvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n              = 1'b0;
        u_if.s_axis_tdata  = '0;
        u_if.s_axis_tkeep  = '0;
        u_if.s_axis_tuser  = '0;
        u_if.s_axis_tvalid = 1'b0;
        u_if.s_axis_tlast  = 1'b0;
        u_if.m_axis_tready = 8'hFF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", u_if.m_axis_tvalid, 8'h00);
        chk("rst_tready", u_if.s_axis_tready, 1'b0);
        chk("rst_drop_count", drop_count, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 3-beat packet to queue 5
        send_pkt(5, 0, 3, 16'h0500, 5, 0);
        @(negedge clk);
        chk("q5_tail_valid", u_if.m_axis_tvalid, 8'h20);
        chk("q5_tail_last", u_if.m_axis_tlast[5], 1'b1);
        repeat (2) @(posedge clk); #1;

        // back-to-back single-beat packets walking all queues
        for (int q = 0; q < NQ; q++) send_pkt(q, 0, 1, 16'h1000 + 16'(q), q, 1);
        u_if.s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("walk_last_valid", u_if.m_axis_tvalid, 8'h80);
        repeat (2) @(posedge clk); #1;

        // 4-beat packet to queue 3 with a mid-packet stall on queue 3 only
        fork
            send_pkt(3, 0, 4, 16'h0300, 3, 0);
            begin
                repeat (2) @(posedge clk);
                #1 u_if.m_axis_tready = 8'hF7;
                repeat (3) @(negedge clk);
                chk("stall_s_tready", u_if.s_axis_tready, 1'b0);
                chk("stall_tvalid", u_if.m_axis_tvalid, 8'h08);
                chk("stall_held_data", u_if.m_axis_tdata[3*DW +: DW], {8{16'h0300, 16'd1}});
                repeat (2) @(posedge clk);
                #1 u_if.m_axis_tready = 8'hFF;
            end
        join
        repeat (3) @(posedge clk); #1;

        // dropped 6-beat packet, then a packet to queue 2
        send_pkt(2, 1, 6, 16'hD000, 2, 1);
        send_pkt(2, 0, 3, 16'h0200, 2, 0);
        @(negedge clk);
        chk("drop_count_one", drop_count, 32'd1);
        repeat (2) @(posedge clk); #1;

        // tuser on non-head beats must not re-steer
        send_pkt(1, 0, 3, 16'h0100, 6, 0);
        repeat (3) @(posedge clk); #1;

        // asynchronous reset while a beat is buffered
        u_if.m_axis_tready = 8'hEF;
        begin
            logic [UW-1:0] u;
            u = '0;
            u[26:24] = 3'd4;
            send_beat(mk_data(16'h0400, 0), 32'hFFFF_FFFF, u, 1'b0);
        end
        u_if.s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", u_if.m_axis_tvalid, 8'h10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", u_if.m_axis_tvalid, 8'h00);
        chk("async_rst_ready", u_if.s_axis_tready, 1'b0);
        chk("async_rst_drops", drop_count, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        u_if.m_axis_tready = 8'hFF;
        @(posedge clk); #1;
        send_pkt(6, 0, 1, 16'h0600, 6, 0);
        @(negedge clk);
        chk("post_rst_valid", u_if.m_axis_tvalid, 8'h40);
        repeat (3) @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
